relu_buffer_l1: RTL and testbench

Post-activation buffer between fully-connected layer 1 and layer 2 of the MNIST pipeline. Captures the 32 Q15 neuron outputs that FC1 emits one at a time, applies ReLU, stores them, then replays the full activation vector to the FC2 input port. FC2 drives its accumulator with `start` held high and `in_valid` strobes, so this block produces exactly that pattern. It also provides an optional `out_ready` throttle for downstream stall.

---
 rtl/mnist_pkg.sv | 17 +
 rtl/relu_buffer_l1_if.sv | 25 ++
 rtl/relu_q15.sv | 12 +
 rtl/relu_buffer_l1.sv | 150 +++++++++++++++
 tb/tb_relu_buffer_l1.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mnist_pkg.sv
// Shared types and sizes for the MNIST inference pipeline.
package mnist_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_L1   = 32;

  // Q15 fixed-point sample, two's complement.
  typedef logic [DATA_W-1:0] q15_t;

  // Activation buffer phases.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    DRAIN  = 2'd1,
    FINISH = 2'd2
  } buf_state_e;

endpackage

// File: rtl/relu_buffer_l1_if.sv
// FC1 -> buffer -> FC2 streaming bus. master is the pipeline side, slave is the buffer.
interface relu_buffer_l1_if;
  import mnist_pkg::*;

  q15_t in_data;
  logic in_valid;
  logic in_done;
  logic out_start;
  q15_t out_data;
  logic out_valid;
  logic out_ready;
  logic done;
  logic overflow;

  modport master (
    output in_data, in_valid, in_done, out_ready,
    input  out_start, out_data, out_valid, done, overflow
  );

  modport slave (
    input  in_data, in_valid, in_done, out_ready,
    output out_start, out_data, out_valid, done, overflow
  );

endinterface

// File: rtl/relu_q15.sv
// Combinational Q15 ReLU: negative samples clamp to zero, others pass unchanged.
module relu_q15
  import mnist_pkg::*;
(
  input  q15_t din,
  output q15_t dout_c
);

  // Sign bit selects zero.
  assign dout_c = din[DATA_W-1] ? '0 : din;

endmodule

// File: rtl/relu_buffer_l1.sv
// Post-ReLU activation buffer between FC1 and FC2: captures a vector, then replays
// all N_NEURONS entries (zero-padded) with out_start held high.
module relu_buffer_l1
  import mnist_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  relu_buffer_l1_if.slave  bus
);

  localparam int unsigned N_NEURONS = N_L1;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned IDX_W     = $clog2(N_NEURONS);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_NEURONS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_NEURONS - 1);

  buf_state_e             state_q, state_d;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic [N_NEURONS-1:0]   written_q, written_d;
  q15_t                   mem_q [N_NEURONS];
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_wa;

  logic                   out_start_q, out_start_d;
  q15_t                   out_data_q,  out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   done_q,      done_d;
  logic                   overflow_q,  overflow_d;

  q15_t                   relu_c;
  logic [CNT_W-1:0]       wr_cnt_inc;
  logic [IDX_W-1:0]       rd_next_idx;
  q15_t                   next_entry_c;
  q15_t                   first_entry_c;

  relu_q15 u_relu (
    .din    (bus.in_data),
    .dout_c (relu_c)
  );

  assign wr_cnt_inc  = wr_cnt_q + CNT_W'(1);
  assign rd_next_idx = IDX_W'(rd_cnt_q) + IDX_W'(1);

  // Unwritten slots read as zero so short vectors are zero-padded.
  assign next_entry_c = written_q[rd_next_idx] ? mem_q[rd_next_idx] : '0;

  // Entry 0 prefetch; when the vector's first write happens on the transition cycle
  // it has not reached the array yet, so bypass the incoming sample.
  assign first_entry_c = written_q[0] ? mem_q[0] : (bus.in_valid ? relu_c : '0);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    written_d   = written_q;
    mem_we      = 1'b0;
    mem_wa      = IDX_W'(wr_cnt_q);
    out_start_d = out_start_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;

    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          mem_we            = 1'b1;
          written_d[mem_wa] = 1'b1;
          wr_cnt_d          = wr_cnt_inc;
        end
        if ((bus.in_valid && (wr_cnt_inc == FULL_CNT)) ||
            (bus.in_done && (bus.in_valid || (wr_cnt_q != '0)))) begin
          state_d     = DRAIN;
          rd_cnt_d    = '0;
          out_start_d = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = first_entry_c;
        end
      end

      DRAIN: begin
        if (bus.in_valid) overflow_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          if (rd_cnt_q == LAST_CNT) begin
            state_d     = FINISH;
            out_start_d = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            done_d      = 1'b1;
          end else begin
            rd_cnt_d   = rd_cnt_q + CNT_W'(1);
            out_data_d = next_entry_c;
          end
        end
      end

      FINISH: begin
        if (bus.in_valid) overflow_d = 1'b1;
        wr_cnt_d  = '0;
        rd_cnt_d  = '0;
        written_d = '0;
        state_d   = FILL;
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      written_q   <= '0;
      out_start_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      written_q   <= written_d;
      out_start_q <= out_start_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  // Activation storage; validity is tracked by written_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= relu_c;
  end

  assign bus.out_start = out_start_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_relu_buffer_l1.sv
// Self-checking bench for relu_buffer_l1 against a vector-level reference model.
module tb_relu_buffer_l1;
  import mnist_pkg::*;

  localparam int unsigned N = N_L1;
  typedef q15_t vec_t [N];

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  relu_buffer_l1_if bus();

  relu_buffer_l1 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ReLU on the signed value.
  function automatic q15_t relu_ref(input q15_t v);
    return ($signed(v) < 0) ? 16'h0000 : v;
  endfunction

  // Expected replay: ReLU of each captured sample, zeros for the unused tail.
  function automatic vec_t model(input q15_t v[$]);
    vec_t e;
    for (int k = 0; k < int'(N); k++) e[k] = (k < v.size()) ? relu_ref(v[k]) : 16'h0000;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // done_mode: 0 none, 1 separate in_done cycle, 2 in_done with the last sample.
  task automatic fill(input q15_t vals[$], input int done_mode, input bit gaps);
    for (int i = 0; i < vals.size(); i++) begin
      if (gaps && i > 0 && i < vals.size() - 1) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = vals[i];
      bus.in_done  = (done_mode == 2) && (i == vals.size() - 1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_done  = 1'b0;
    bus.in_data  = '0;
    if (done_mode == 1) begin
      bus.in_done = 1'b1;
      tick();
      bus.in_done = 1'b0;
    end
  endtask

  // Observes a replay. mode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic drain(input int mode, input int drop_at, output q15_t got[$],
                       output int hs_c, output int done_c, output int n_done,
                       output int stall_err, output int idle_err, output int ovf_c,
                       output logic done_start);
    bit   stalled;
    bit   ready;
    q15_t held;
    stalled = 1'b0; held = '0; got.delete();
    hs_c = -1; done_c = -1; n_done = 0; stall_err = 0; idle_err = 0; ovf_c = -1;
    done_start = 1'bx;
    for (int c = 0; c < 400; c++) begin
      if (stalled && (bus.out_valid !== 1'b1 || bus.out_data !== held)) stall_err++;
      if (bus.out_valid === 1'b1 && bus.out_start !== 1'b1) idle_err++;
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_c < 0) begin done_c = c; done_start = bus.out_start; end
      end
      if (done_c >= 0 && bus.out_valid !== 1'b0) idle_err++;
      if (bus.overflow === 1'b1 && ovf_c < 0) ovf_c = c;
      if (done_c >= 0 && c >= done_c + 3) break;
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (c % 4 == 0) || (c % 4 == 3);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = ready;
      bus.in_valid  = (c == drop_at);
      bus.in_data   = (c == drop_at) ? 16'h5555 : 16'h0000;
      if (bus.out_valid === 1'b1 && ready) begin
        got.push_back(bus.out_data);
        hs_c    = c;
        stalled = 1'b0;
      end else if (bus.out_valid === 1'b1) begin
        stalled = 1'b1;
        held    = bus.out_data;
      end else begin
        stalled = 1'b0;
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.out_start !== 1'b0) begin failures++; $display("FAIL reset_out_start got %b exp 0", bus.out_start); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got %h exp 0000", bus.out_data); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
  endtask

  task automatic test_ordered();
    q15_t vals[$]; q15_t got[$]; vec_t e;
    int hs_c, done_c, n_done, stall_err, idle_err, ovf_c; logic ds;
    for (int k = 0; k < int'(N); k++) vals.push_back(DATA_W'(256 * (k + 1) - 4096));
    e = model(vals);
    fill(vals, 0, 1'b0);
    drain(0, -1, got, hs_c, done_c, n_done, stall_err, idle_err, ovf_c, ds);
    checks++; if (got.size() != int'(N)) begin failures++; $display("FAIL ordered_count got %0d exp %0d", got.size(), N); end
    for (int k = 0; k < got.size() && k < int'(N); k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL ordered_data[%0d] got %h exp %h", k, got[k], e[k]); end
    end
    checks++; if (hs_c != 31) begin failures++; $display("FAIL ordered_last_xfer got %0d exp 31", hs_c); end
    checks++; if (done_c != 32) begin failures++; $display("FAIL ordered_done_latency got %0d exp 32", done_c); end
    checks++; if (ds !== 1'b0) begin failures++; $display("FAIL ordered_done_start got %b exp 0", ds); end
    checks++; if (n_done != 1 || idle_err != 0) begin failures++; $display("FAIL ordered_pulse got dones=%0d idle_err=%0d exp 1/0", n_done, idle_err); end
  endtask

  task automatic test_relu_extremes();
    q15_t vals[$]; q15_t got[$]; vec_t e;
    int hs_c, done_c, n_done, stall_err, idle_err, ovf_c; logic ds;
    vals = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
    e = model(vals);
    fill(vals, 1, 1'b0);
    drain(0, -1, got, hs_c, done_c, n_done, stall_err, idle_err, ovf_c, ds);
    checks++; if (got.size() != int'(N)) begin failures++; $display("FAIL extremes_count got %0d exp %0d", got.size(), N); end
    for (int k = 0; k < got.size() && k < int'(N); k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL extremes_data[%0d] got %h exp %h", k, got[k], e[k]); end
    end
    checks++; if (done_c != 32) begin failures++; $display("FAIL extremes_done_latency got %0d exp 32", done_c); end
  endtask

  task automatic test_short_vector();
    q15_t vals[$]; q15_t got[$]; vec_t e;
    int hs_c, done_c, n_done, stall_err, idle_err, ovf_c; logic ds;
    repeat (10) vals.push_back(16'h1234);
    e = model(vals);
    fill(vals, 1, 1'b1);
    drain(0, -1, got, hs_c, done_c, n_done, stall_err, idle_err, ovf_c, ds);
    checks++; if (got.size() != int'(N)) begin failures++; $display("FAIL short_count got %0d exp %0d", got.size(), N); end
    for (int k = 0; k < got.size() && k < int'(N); k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL short_data[%0d] got %h exp %h", k, got[k], e[k]); end
    end
    checks++; if (n_done != 1) begin failures++; $display("FAIL short_done_pulses got %0d exp 1", n_done); end
  endtask

  task automatic test_done_edges();
    q15_t vals[$]; q15_t got[$]; vec_t e;
    int hs_c, done_c, n_done, stall_err, idle_err, ovf_c; logic ds;
    bus.in_done = 1'b1;
    tick();
    bus.in_done = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_start !== 1'b0) begin failures++; $display("FAIL empty_done_ignored got valid=%b start=%b exp 0/0", bus.out_valid, bus.out_start); end
    vals.push_back(16'($urandom_range(1, 16'h7FFF)));
    e = model(vals);
    fill(vals, 2, 1'b0);
    drain(0, -1, got, hs_c, done_c, n_done, stall_err, idle_err, ovf_c, ds);
    checks++; if (got.size() != int'(N)) begin failures++; $display("FAIL same_cycle_count got %0d exp %0d", got.size(), N); end
    for (int k = 0; k < got.size() && k < int'(N); k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL same_cycle_data[%0d] got %h exp %h", k, got[k], e[k]); end
    end
    checks++; if (done_c != 32) begin failures++; $display("FAIL same_cycle_done_latency got %0d exp 32", done_c); end
  endtask

  task automatic test_backpressure();
    q15_t vals[$]; q15_t got[$]; vec_t e;
    int hs_c, done_c, n_done, stall_err, idle_err, ovf_c; logic ds;
    for (int k = 0; k < int'(N); k++) vals.push_back(16'($urandom));
    e = model(vals);
    fill(vals, 0, 1'b1);
    drain(1, -1, got, hs_c, done_c, n_done, stall_err, idle_err, ovf_c, ds);
    checks++; if (got.size() != int'(N)) begin failures++; $display("FAIL bp_count got %0d exp %0d", got.size(), N); end
    for (int k = 0; k < got.size() && k < int'(N); k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL bp_data[%0d] got %h exp %h", k, got[k], e[k]); end
    end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stall_stable got %0d unstable cycles exp 0", stall_err); end
    checks++; if (done_c != hs_c + 1 || done_c < 0) begin failures++; $display("FAIL bp_done_timing got done=%0d last_xfer=%0d exp done=last_xfer+1", done_c, hs_c); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL bp_done_pulses got %0d exp 1", n_done); end
  endtask

  task automatic test_drop();
    q15_t vals[$]; q15_t got[$]; vec_t e;
    int hs_c, done_c, n_done, stall_err, idle_err, ovf_c; logic ds;
    for (int k = 0; k < int'(N); k++) vals.push_back(16'($urandom));
    e = model(vals);
    fill(vals, 0, 1'b0);
    drain(0, 5, got, hs_c, done_c, n_done, stall_err, idle_err, ovf_c, ds);
    checks++; if (ovf_c != 6) begin failures++; $display("FAIL drop_overflow_cycle got %0d exp 6", ovf_c); end
    checks++; if (got.size() != int'(N)) begin failures++; $display("FAIL drop_count got %0d exp %0d", got.size(), N); end
    for (int k = 0; k < got.size() && k < int'(N); k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL drop_data[%0d] got %h exp %h", k, got[k], e[k]); end
    end
    vals.delete();
    repeat (20) vals.push_back(16'($urandom));
    e = model(vals);
    fill(vals, 1, 1'b1);
    drain(2, -1, got, hs_c, done_c, n_done, stall_err, idle_err, ovf_c, ds);
    checks++; if (got.size() != int'(N)) begin failures++; $display("FAIL drop_next_count got %0d exp %0d", got.size(), N); end
    for (int k = 0; k < got.size() && k < int'(N); k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL drop_next_data[%0d] got %h exp %h", k, got[k], e[k]); end
    end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL drop_sticky got %b exp 1", bus.overflow); end
  endtask

  task automatic test_reset_mid_drain();
    q15_t vals[$]; q15_t got[$]; vec_t e;
    int hs_c, done_c, n_done, stall_err, idle_err, ovf_c; logic ds;
    for (int k = 0; k < int'(N); k++) vals.push_back(16'($urandom));
    e = model(vals);
    fill(vals, 0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (7) tick();
    checks++; if (bus.out_data !== e[7] || bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_entry7 got %h/%b exp %h/1", bus.out_data, bus.out_valid, e[7]); end
    reset = 1'b1;
    #1;
    checks++; if (bus.out_start !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 ||
                  bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got start=%b valid=%b data=%h done=%b ovf=%b exp all 0",
               bus.out_start, bus.out_valid, bus.out_data, bus.done, bus.overflow);
    end
    tick();
    reset = 1'b0;
    tick();
    vals.delete();
    for (int k = 0; k < int'(N); k++) vals.push_back(16'($urandom));
    e = model(vals);
    fill(vals, 0, 1'b1);
    drain(2, -1, got, hs_c, done_c, n_done, stall_err, idle_err, ovf_c, ds);
    checks++; if (got.size() != int'(N)) begin failures++; $display("FAIL post_reset_count got %0d exp %0d", got.size(), N); end
    for (int k = 0; k < got.size() && k < int'(N); k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL post_reset_data[%0d] got %h exp %h", k, got[k], e[k]); end
    end
    checks++; if (n_done != 1) begin failures++; $display("FAIL post_reset_done_pulses got %0d exp 1", n_done); end
  endtask

  task automatic test_random_vectors();
    q15_t vals[$]; q15_t got[$]; vec_t e;
    int hs_c, done_c, n_done, stall_err, idle_err, ovf_c; logic ds;
    int len, dm;
    for (int it = 0; it < 4; it++) begin
      vals.delete();
      len = int'($urandom_range(1, N));
      for (int k = 0; k < len; k++) vals.push_back(16'($urandom));
      if (len == int'(N)) dm = ($urandom_range(0, 1) == 0) ? 0 : 2;
      else                dm = ($urandom_range(0, 1) == 0) ? 1 : 2;
      e = model(vals);
      fill(vals, dm, 1'b1);
      drain(2, -1, got, hs_c, done_c, n_done, stall_err, idle_err, ovf_c, ds);
      checks++; if (got.size() != int'(N)) begin failures++; $display("FAIL rand%0d_count got %0d exp %0d", it, got.size(), N); end
      for (int k = 0; k < got.size() && k < int'(N); k++) begin
        checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL rand%0d_data[%0d] got %h exp %h", it, k, got[k], e[k]); end
      end
      checks++; if (stall_err != 0 || n_done != 1 || done_c != hs_c + 1) begin
        failures++;
        $display("FAIL rand%0d_protocol got stall_err=%0d dones=%0d done=%0d last_xfer=%0d exp 0/1/last_xfer+1",
                 it, stall_err, n_done, done_c, hs_c);
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_done   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_ordered();
    test_relu_extremes();
    test_short_vector();
    test_done_edges();
    test_backpressure();
    test_random_vectors();
    test_drop();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
